// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Control FSM for the program-counter datapath, the stack /
//            scratch-RAM push-pop handshake and the interrupt-enable flag.
//            States INIT -> FETCH -> EXEC (-> INTR) -> FETCH ...
//            Outputs are decoded combinationally from the current state
//            (and from the opcode and flags while in EXEC).
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] OPCODE_HI_5,
  input  logic [1:0] OPCODE_LO_2,
  input  logic       C_FLAG,
  input  logic       Z_FLAG,
  input  logic       INTR,
  output logic       PC_RST,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic [1:0] PC_MUX_SEL,
  output logic       SP_INCR,
  output logic       SP_DECR,
  output logic       SCR_WE,
  output logic       SCR_DATA_SEL,
  output logic [1:0] SCR_ADDR_SEL,
  output logic       FLG_SHAD_LD,
  output logic       FLG_LD_SEL,
  output logic       I_FLAG
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  // Seven-bit opcode = {instr[17:13], instr[1:0]}
  localparam logic [6:0] C_OP_BRN   = 7'b0010000;
  localparam logic [6:0] C_OP_CALL  = 7'b0010001;
  localparam logic [6:0] C_OP_BREQ  = 7'b0010010;
  localparam logic [6:0] C_OP_BRNE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRCS  = 7'b0010100;
  localparam logic [6:0] C_OP_BRCC  = 7'b0010101;
  localparam logic [6:0] C_OP_RET   = 7'b0110010;
  localparam logic [6:0] C_OP_SEI   = 7'b0110100;
  localparam logic [6:0] C_OP_CLI   = 7'b0110101;
  localparam logic [6:0] C_OP_RETID = 7'b0110110;
  localparam logic [6:0] C_OP_RETIE = 7'b0110111;

  localparam logic [1:0] C_SEL_IMM   = 2'd0;
  localparam logic [1:0] C_SEL_STACK = 2'd1;
  localparam logic [1:0] C_SEL_VEC   = 2'd2;

  localparam logic [1:0] C_ADDR_SP    = 2'd2;
  localparam logic [1:0] C_ADDR_SP_M1 = 2'd3;

  state_t     state_q, state_d;
  logic       ie_q, ie_d;
  logic [6:0] w_opcode;

  assign w_opcode = {OPCODE_HI_5, OPCODE_LO_2};
  assign I_FLAG   = ie_q;

  // Output decode plus next-state / next-IE computation.
  always_comb begin
    PC_RST       = 1'b0;
    PC_INC       = 1'b0;
    PC_LD        = 1'b0;
    PC_MUX_SEL   = C_SEL_IMM;
    SP_INCR      = 1'b0;
    SP_DECR      = 1'b0;
    SCR_WE       = 1'b0;
    SCR_DATA_SEL = 1'b0;
    SCR_ADDR_SEL = 2'd0;
    FLG_SHAD_LD  = 1'b0;
    FLG_LD_SEL   = 1'b0;
    ie_d         = ie_q;
    state_d      = state_q;

    case (state_q)
      ST_INIT: begin
        PC_RST  = 1'b1;
        state_d = ST_FETCH;
      end

      // PC is bumped here so that PC_COUNT in EXEC is the return address.
      ST_FETCH: begin
        PC_INC  = 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        case (w_opcode)
          C_OP_BRN:  PC_LD = 1'b1;
          C_OP_BREQ: PC_LD = Z_FLAG;
          C_OP_BRNE: PC_LD = ~Z_FLAG;
          C_OP_BRCS: PC_LD = C_FLAG;
          C_OP_BRCC: PC_LD = ~C_FLAG;
          C_OP_CALL: begin
            PC_LD        = 1'b1;
            SCR_WE       = 1'b1;
            SCR_DATA_SEL = 1'b1;
            SCR_ADDR_SEL = C_ADDR_SP_M1;
            SP_DECR      = 1'b1;
          end
          C_OP_RET, C_OP_RETID, C_OP_RETIE: begin
            PC_LD        = 1'b1;
            PC_MUX_SEL   = C_SEL_STACK;
            SCR_ADDR_SEL = C_ADDR_SP;
            SP_INCR      = 1'b1;
            // RETID/RETIE also restore the flags saved at interrupt entry.
            if (w_opcode != C_OP_RET) begin
              FLG_LD_SEL = 1'b1;
              ie_d       = w_opcode[0];
            end
          end
          C_OP_SEI: ie_d = 1'b1;
          C_OP_CLI: ie_d = 1'b0;
          default: ;
        endcase
        // Interrupt gating uses the post-instruction IE value.
        state_d = (INTR && ie_d) ? ST_INTR : ST_FETCH;
      end

      // Interrupt entry: push current PC, jump to vector, shadow flags.
      ST_INTR: begin
        PC_LD        = 1'b1;
        PC_MUX_SEL   = C_SEL_VEC;
        SCR_WE       = 1'b1;
        SCR_DATA_SEL = 1'b1;
        SCR_ADDR_SEL = C_ADDR_SP_M1;
        SP_DECR      = 1'b1;
        FLG_SHAD_LD  = 1'b1;
        ie_d         = 1'b0;
        state_d      = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State and interrupt-enable registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed-vector bench for pc_sequencer. Output bus is packed
//            as {PC_RST,PC_INC,PC_LD,PC_MUX_SEL,SP_INCR,SP_DECR,SCR_WE,
//            SCR_DATA_SEL,SCR_ADDR_SEL,FLG_SHAD_LD,FLG_LD_SEL,I_FLAG}.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] OPCODE_HI_5;
  logic [1:0] OPCODE_LO_2;
  logic       C_FLAG, Z_FLAG, INTR;
  logic       PC_RST, PC_INC, PC_LD, SP_INCR, SP_DECR, SCR_WE, SCR_DATA_SEL;
  logic       FLG_SHAD_LD, FLG_LD_SEL, I_FLAG;
  logic [1:0] PC_MUX_SEL, SCR_ADDR_SEL;
  logic [13:0] w_outs;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [6:0] C_NOP   = 7'b0000000;
  localparam logic [6:0] C_BRN   = 7'b0010000;
  localparam logic [6:0] C_CALL  = 7'b0010001;
  localparam logic [6:0] C_BREQ  = 7'b0010010;
  localparam logic [6:0] C_BRNE  = 7'b0010011;
  localparam logic [6:0] C_BRCS  = 7'b0010100;
  localparam logic [6:0] C_BRCC  = 7'b0010101;
  localparam logic [6:0] C_RET   = 7'b0110010;
  localparam logic [6:0] C_SEI   = 7'b0110100;
  localparam logic [6:0] C_CLI   = 7'b0110101;
  localparam logic [6:0] C_RETID = 7'b0110110;
  localparam logic [6:0] C_RETIE = 7'b0110111;

  always #5 CLK = ~CLK;

  pc_sequencer u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .OPCODE_HI_5  (OPCODE_HI_5),
    .OPCODE_LO_2  (OPCODE_LO_2),
    .C_FLAG       (C_FLAG),
    .Z_FLAG       (Z_FLAG),
    .INTR         (INTR),
    .PC_RST       (PC_RST),
    .PC_INC       (PC_INC),
    .PC_LD        (PC_LD),
    .PC_MUX_SEL   (PC_MUX_SEL),
    .SP_INCR      (SP_INCR),
    .SP_DECR      (SP_DECR),
    .SCR_WE       (SCR_WE),
    .SCR_DATA_SEL (SCR_DATA_SEL),
    .SCR_ADDR_SEL (SCR_ADDR_SEL),
    .FLG_SHAD_LD  (FLG_SHAD_LD),
    .FLG_LD_SEL   (FLG_LD_SEL),
    .I_FLAG       (I_FLAG)
  );

  assign w_outs = {PC_RST, PC_INC, PC_LD, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE,
                   SCR_DATA_SEL, SCR_ADDR_SEL, FLG_SHAD_LD, FLG_LD_SEL, I_FLAG};

  // Expected-vector builders (hand-written from the output tables)
  function automatic logic [13:0] f_init(input logic i);
    f_init = {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, i};
  endfunction
  function automatic logic [13:0] f_fetch(input logic i);
    f_fetch = {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, i};
  endfunction
  function automatic logic [13:0] f_br(input logic ld, input logic i);
    f_br = {1'b0, 1'b0, ld, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, i};
  endfunction
  function automatic logic [13:0] f_call(input logic i);
    f_call = {1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, i};
  endfunction
  function automatic logic [13:0] f_ret(input logic fls, input logic i);
    f_ret = {1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, fls, i};
  endfunction
  function automatic logic [13:0] f_intr(input logic i);
    f_intr = {1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, i};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op);
    OPCODE_HI_5 = op[6:2];
    OPCODE_LO_2 = op[1:0];
  endtask

  // Branch table: opcode, C, Z, expected PC_LD
  logic [6:0] br_op  [10] = '{C_BRN, C_BREQ, C_BREQ, C_BRNE, C_BRNE,
                              C_BRCS, C_BRCS, C_BRCC, C_BRCC, 7'b0110000};
  logic       br_c   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       br_z   [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       br_ld  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    RST = 1'b1; INTR = 1'b0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
    set_op(C_NOP);
    step();
    step();
    check("reset_init", w_outs, f_init(1'b0));

    // Release reset: INIT -> FETCH -> EXEC -> FETCH
    RST = 1'b0;
    #1;
    check("init_hold", w_outs, f_init(1'b0));
    step(); check("first_fetch", w_outs, f_fetch(1'b0));
    step(); check("first_exec_nop", w_outs, f_br(1'b0, 1'b0));
    step(); check("second_fetch", w_outs, f_fetch(1'b0));

    // Branch conditions (each from FETCH: EXEC check, then back to FETCH)
    for (int k = 0; k < 10; k++) begin
      set_op(br_op[k]); C_FLAG = br_c[k]; Z_FLAG = br_z[k];
      step(); check($sformatf("branch_%0d", k), w_outs, f_br(br_ld[k], 1'b0));
      step(); check($sformatf("branch_%0d_fetch", k), w_outs, f_fetch(1'b0));
    end
    C_FLAG = 1'b0; Z_FLAG = 1'b0;

    // CALL then RET
    set_op(C_CALL);
    step(); check("call", w_outs, f_call(1'b0));
    step(); check("call_fetch", w_outs, f_fetch(1'b0));
    set_op(C_RET);
    step(); check("ret", w_outs, f_ret(1'b0, 1'b0));
    step(); check("ret_fetch", w_outs, f_fetch(1'b0));

    // SEI, then interrupt during a NOP EXEC
    set_op(C_SEI);
    step(); check("sei_exec", w_outs, f_br(1'b0, 1'b0));
    step(); check("sei_fetch_ie", w_outs, f_fetch(1'b1));
    set_op(C_NOP); INTR = 1'b1;
    step(); check("nop_exec_ie", w_outs, f_br(1'b0, 1'b1));
    step(); check("intr_entry", w_outs, f_intr(1'b1));
    step(); check("post_intr_fetch", w_outs, f_fetch(1'b0));
    step(); check("held_intr_exec", w_outs, f_br(1'b0, 1'b0));
    step(); check("held_intr_no_reentry", w_outs, f_fetch(1'b0));

    // RETIE restores flags and re-enables interrupts
    INTR = 1'b0; set_op(C_RETIE);
    step(); check("retie", w_outs, f_ret(1'b1, 1'b0));
    step(); check("retie_fetch_ie", w_outs, f_fetch(1'b1));

    // CLI with INTR pending blocks entry
    set_op(C_CLI); INTR = 1'b1;
    step(); check("cli_exec", w_outs, f_br(1'b0, 1'b1));
    step(); check("cli_blocks_intr", w_outs, f_fetch(1'b0));

    // RETID with INTR pending also blocks entry
    set_op(C_SEI); INTR = 1'b0;
    step(); step();
    set_op(C_RETID); INTR = 1'b1;
    step(); check("retid", w_outs, f_ret(1'b1, 1'b1));
    step(); check("retid_blocks_intr", w_outs, f_fetch(1'b0));

    // Taken branch coinciding with interrupt, entered via SEI in same EXEC
    set_op(C_SEI);
    step(); check("sei_intr_exec", w_outs, f_br(1'b0, 1'b0));
    step(); check("sei_permits_intr", w_outs, f_intr(1'b1));
    step(); check("intr_to_fetch", w_outs, f_fetch(1'b0));
    set_op(C_SEI); INTR = 1'b0;
    step(); step();
    set_op(C_BRN); INTR = 1'b1;
    step(); check("brn_with_intr", w_outs, f_br(1'b1, 1'b1));
    step(); check("brn_then_intr", w_outs, f_intr(1'b1));

    // Reset asserted while in INTR
    RST = 1'b1;
    step(); check("rst_from_intr", w_outs, f_init(1'b0));
    RST = 1'b0; INTR = 1'b0; set_op(C_NOP);
    step(); check("rst_recover_fetch", w_outs, f_fetch(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
